// File: rtl/stream_host_master_pkg.sv
// Shared constants and types for the byte-stream command protocol between the
// host master and the picture-transfer controller.
package stream_host_master_pkg;

  localparam logic [7:0] CMD_TEST  = 8'h74;
  localparam logic [7:0] CMD_CLEAR = 8'h63;
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;
  localparam logic [7:0] REPLY_OK  = 8'h79;

  localparam int unsigned WORDS_PER_IMAGE = 32'd25344;
  localparam int unsigned UPLOAD_BASE     = 32'd0;
  localparam int unsigned DOWNLOAD_BASE   = 32'd25344;

  typedef enum logic [1:0] {
    OP_TEST  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND_CMD  = 4'd1,
    ST_GAP_CMD   = 4'd2,
    ST_RECV      = 4'd3,
    ST_CLR_WAIT  = 4'd4,
    ST_FETCH     = 4'd5,
    ST_LATCH     = 4'd6,
    ST_SEND      = 4'd7,
    ST_GAP_DATA  = 4'd8,
    ST_DONE      = 4'd9
  } state_e;

  function automatic logic [7:0] cmd_byte(input cmd_op_e op);
    logic [7:0] b;
    case (op)
      OP_TEST:  b = CMD_TEST;
      OP_CLEAR: b = CMD_CLEAR;
      OP_WRITE: b = CMD_WRITE;
      OP_READ:  b = CMD_READ;
      default:  b = CMD_TEST;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/stream_host_master_if.sv
// Command, word-memory and byte-stream signals of the host master.
// master = the host master itself; slave = its environment (user, memories, controller).
interface stream_host_master_if #(
  parameter int unsigned ADDR_W = 15
) ();
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ready;
  logic              done;
  logic              error;
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       src_dr;
  logic              snk_we;
  logic [ADDR_W-1:0] snk_addr;
  logic [31:0]       snk_dw;
  logic [7:0]        s_tx_data;
  logic              s_tx_stb;
  logic [7:0]        s_rx_data;
  logic              s_rx_stb;
  logic              s_rx_ack;

  modport master (
    input  cmd_valid, cmd_op, src_dr, s_rx_data, s_rx_stb,
    output cmd_ready, done, error, src_en, src_addr, snk_we, snk_addr, snk_dw,
           s_tx_data, s_tx_stb, s_rx_ack
  );

  modport slave (
    output cmd_valid, cmd_op, src_dr, s_rx_data, s_rx_stb,
    input  cmd_ready, done, error, src_en, src_addr, snk_we, snk_addr, snk_dw,
           s_tx_data, s_tx_stb, s_rx_ack
  );
endinterface

// File: rtl/stream_host_master.sv
// Host-side initiator issuing test/clear/write/read byte sequences to the
// picture-transfer controller. All outputs except s_rx_ack are registered.
module stream_host_master
  import stream_host_master_pkg::*;
#(
  parameter int unsigned WORDS      = WORDS_PER_IMAGE,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned BYTE_GAP   = 2,
  parameter int unsigned CLEAR_WAIT = 65540,
  parameter int unsigned TIMEOUT    = 1 << 20
) (
  input  logic                clk,
  input  logic                reset,
  stream_host_master_if.master bus
);

  localparam int unsigned WAIT_MAX = (CLEAR_WAIT > TIMEOUT) ? CLEAR_WAIT : TIMEOUT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(BYTE_GAP - 1);
  localparam logic [WAIT_W-1:0] CLR_LAST  = WAIT_W'(CLEAR_WAIT - 1);
  localparam logic [WAIT_W-1:0] TMO_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       shift_q, shift_d;
  logic              error_q, error_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              done_q, done_d;
  logic              src_en_q, src_en_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              snk_we_q, snk_we_d;
  logic [ADDR_W-1:0] snk_addr_q, snk_addr_d;
  logic [31:0]       snk_dw_q, snk_dw_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_stb_q, tx_stb_d;
  logic              rx_ack_s;

  // A held byte is taken on the very edge it is acked, so acks may run one per cycle.
  assign rx_ack_s = bus.s_rx_stb & (state_q == ST_RECV);

  // Next-state, counter and datapath decode; registered outputs derive from state_d.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    wait_d     = wait_q;
    shift_d    = shift_q;
    error_d    = error_q;
    snk_we_d   = 1'b0;
    snk_addr_d = snk_addr_q;
    snk_dw_d   = snk_dw_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = cmd_op_e'(bus.cmd_op);
          error_d    = 1'b0;
          word_cnt_d = '0;
          byte_idx_d = 2'd0;
          wait_d     = '0;
          state_d    = ST_SEND_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_CMD: begin
        wait_d  = '0;
        state_d = ST_GAP_CMD;
      end
      ST_GAP_CMD: begin
        if (wait_q == GAP_LAST) begin
          wait_d = '0;
          case (op_q)
            OP_TEST:  state_d = ST_RECV;
            OP_CLEAR: state_d = ST_CLR_WAIT;
            OP_WRITE: state_d = ST_FETCH;
            OP_READ:  state_d = ST_RECV;
            default:  state_d = ST_DONE;
          endcase
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_CLR_WAIT: begin
        if (wait_q == CLR_LAST) begin
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d = bus.src_dr;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        wait_d  = '0;
        state_d = ST_GAP_DATA;
      end
      ST_GAP_DATA: begin
        if (wait_q == GAP_LAST) begin
          wait_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            if (word_cnt_q == WORD_LAST) begin
              state_d = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = ST_FETCH;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            state_d    = ST_SEND;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (rx_ack_s) begin
          wait_d  = '0;
          shift_d = {bus.s_rx_data, shift_q[31:8]};
          if (op_q == OP_TEST) begin
            if (bus.s_rx_data != REPLY_OK) begin
              error_d = 1'b1;
            end else begin
              error_d = error_q;
            end
            state_d = ST_DONE;
          end else if (byte_idx_q == 2'd3) begin
            // Word write overlaps the next byte so a continuously held stream never stalls.
            snk_we_d   = 1'b1;
            snk_addr_d = word_cnt_q;
            snk_dw_d   = shift_d;
            byte_idx_d = 2'd0;
            if (word_cnt_q == WORD_LAST) begin
              state_d = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (wait_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
    src_en_d    = (state_d == ST_FETCH);
    src_addr_d  = (state_d == ST_FETCH) ? word_cnt_d : src_addr_q;
    tx_stb_d    = (state_d == ST_SEND_CMD) || (state_d == ST_SEND);
    if (state_d == ST_SEND_CMD) begin
      tx_data_d = cmd_byte(op_d);
    end else if (state_d == ST_SEND) begin
      tx_data_d = shift_d[7:0];
    end else begin
      tx_data_d = 8'h00;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_TEST;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      wait_q     <= '0;
      shift_q    <= 32'h0000_0000;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      wait_q     <= wait_d;
      shift_q    <= shift_d;
      error_q    <= error_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      src_en_q    <= 1'b0;
      src_addr_q  <= '0;
      snk_we_q    <= 1'b0;
      snk_addr_q  <= '0;
      snk_dw_q    <= 32'h0000_0000;
      tx_data_q   <= 8'h00;
      tx_stb_q    <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      src_en_q    <= src_en_d;
      src_addr_q  <= src_addr_d;
      snk_we_q    <= snk_we_d;
      snk_addr_q  <= snk_addr_d;
      snk_dw_q    <= snk_dw_d;
      tx_data_q   <= tx_data_d;
      tx_stb_q    <= tx_stb_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.src_en    = src_en_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.snk_we    = snk_we_q;
  assign bus.snk_addr  = snk_addr_q;
  assign bus.snk_dw    = snk_dw_q;
  assign bus.s_tx_data = tx_data_q;
  assign bus.s_tx_stb  = tx_stb_q;
  assign bus.s_rx_ack  = rx_ack_s;

endmodule

// File: tb/tb_stream_host_master.sv
// Directed bench for stream_host_master with a small image size, a source ROM,
// a sink RAM, a byte logger and a queued reply stub standing in for the controller.
module tb_stream_host_master;
  import stream_host_master_pkg::*;

  localparam int unsigned WORDS      = 4;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned BYTE_GAP   = 2;
  localparam int unsigned CLEAR_WAIT = 65540;
  localparam int unsigned TIMEOUT    = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_host_master_if #(.ADDR_W(ADDR_W)) bus ();

  stream_host_master #(
    .WORDS(WORDS), .ADDR_W(ADDR_W), .BYTE_GAP(BYTE_GAP),
    .CLEAR_WAIT(CLEAR_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src_word(input int i);
    return 32'(i) * 32'h0101_0101 + 32'h0302_0100;
  endfunction

  function automatic logic [31:0] rd_word(input int k);
    return 32'(k) ^ 32'hA5A5_A5A5;
  endfunction

  // Environment state
  int          cyc = 0;
  logic [7:0]  tx_log [0:63];
  int          tx_cyc [0:63];
  int          tx_n = 0;
  logic [31:0] snk_mem [0:WORDS-1];
  int          snk_n = 0;
  int          done_n = 0;
  int          overlap_n = 0;
  int          ack_cyc [0:63];
  int          ack_n = 0;
  logic [7:0]  rx_buf [0:63];
  int          rx_head = 0;
  int          rx_tail = 0;
  logic        rx_en = 1'b0;

  assign bus.s_rx_stb  = rx_en && (rx_head != rx_tail);
  assign bus.s_rx_data = rx_buf[rx_head[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.src_en) bus.src_dr <= src_word(int'(bus.src_addr));
    if (bus.snk_we) begin
      snk_mem[bus.snk_addr] <= bus.snk_dw;
      snk_n <= snk_n + 1;
    end
    if (bus.s_tx_stb) begin
      tx_log[tx_n[5:0]] <= bus.s_tx_data;
      tx_cyc[tx_n[5:0]] <= cyc;
      tx_n <= tx_n + 1;
    end
    if (bus.done) done_n <= done_n + 1;
    if (bus.done && bus.cmd_ready) overlap_n <= overlap_n + 1;
    if (bus.s_rx_ack) begin
      rx_head <= rx_head + 1;
      ack_cyc[ack_n[5:0]] <= cyc;
      ack_n <= ack_n + 1;
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_buf[rx_tail[5:0]] = b;
    rx_tail = rx_tail + 1;
  endtask

  task automatic issue(input logic [1:0] op);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit ok;
    d0 = done_n;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_n != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    int         reply;     // 0 none, 1 'y', 2 'n', 3 full image of read words
    logic       exp_err;
    int         exp_tx;
    logic [7:0] exp_cmd;
    int         exp_snk;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int tx0, snk0, done0, ack0;

    vecs[0] = '{op: 2'd0, reply: 1, exp_err: 1'b0, exp_tx: 1, exp_cmd: 8'h74, exp_snk: 0};
    vecs[1] = '{op: 2'd0, reply: 2, exp_err: 1'b1, exp_tx: 1, exp_cmd: 8'h74, exp_snk: 0};
    vecs[2] = '{op: 2'd2, reply: 0, exp_err: 1'b0, exp_tx: 17, exp_cmd: 8'h77, exp_snk: 0};
    vecs[3] = '{op: 2'd3, reply: 3, exp_err: 1'b0, exp_tx: 1, exp_cmd: 8'h72, exp_snk: 4};
    vecs[4] = '{op: 2'd0, reply: 0, exp_err: 1'b1, exp_tx: 1, exp_cmd: 8'h74, exp_snk: 0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_tx_stb", 32'(bus.s_tx_stb), 32'd0);
    check("rst_src_en", 32'(bus.src_en), 32'd0);
    check("rst_snk_we", 32'(bus.snk_we), 32'd0);
    check("rst_tx_data", 32'(bus.s_tx_data), 32'd0);
    check("rst_src_addr", 32'(bus.src_addr), 32'd0);
    reset = 1'b0;

    // Unsolicited byte while idle must not be acked
    ack0 = ack_n;
    push_rx(8'h79);
    rx_en = 1'b1;
    repeat (10) @(negedge clk);
    check("unsolicited_ack", 32'(ack_n - ack0), 32'd0);
    rx_en = 1'b0;
    rx_tail = rx_head;

    for (int v = 0; v < 5; v++) begin
      tx0 = tx_n; snk0 = snk_n; done0 = done_n; ack0 = ack_n;
      case (vecs[v].reply)
        1: push_rx(8'h79);
        2: push_rx(8'h6E);
        3: for (int k = 0; k < int'(WORDS); k++)
             for (int b = 0; b < 4; b++) push_rx(8'(rd_word(k) >> (8 * b)));
        default: ;
      endcase
      rx_en = 1'b1;
      issue(vecs[v].op);
      wait_done($sformatf("vec%0d", v), 2000);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_error", v), 32'(bus.error), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_tx_count", v), 32'(tx_n - tx0), 32'(vecs[v].exp_tx));
      check($sformatf("vec%0d_cmd_byte", v), 32'(tx_log[tx0]), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d_snk_count", v), 32'(snk_n - snk0), 32'(vecs[v].exp_snk));
      check($sformatf("vec%0d_done_once", v), 32'(done_n - done0), 32'd1);
      if (vecs[v].op == 2'd2) begin
        for (int w = 0; w < int'(WORDS); w++)
          for (int b = 0; b < 4; b++)
            check($sformatf("write_w%0d_b%0d", w, b), 32'(tx_log[tx0 + 1 + 4 * w + b]),
                  32'(8'(src_word(w) >> (8 * b))));
      end
      if (vecs[v].op == 2'd3) begin
        for (int k = 0; k < int'(WORDS); k++)
          check($sformatf("read_word%0d", k), snk_mem[k], rd_word(k));
        check("read_ack_back_to_back", 32'(ack_cyc[ack0 + 15] - ack_cyc[ack0]), 32'd15);
      end
      rx_en = 1'b0;
      rx_tail = rx_head;
    end

    // Reply stalls after one and a half words of a READ
    tx0 = tx_n; snk0 = snk_n;
    for (int b = 0; b < 4; b++) push_rx(8'(32'h1122_3344 >> (8 * b)));
    push_rx(8'hAA);
    push_rx(8'hBB);
    rx_en = 1'b1;
    issue(2'd3);
    wait_done("stall", 500);
    @(negedge clk);
    check("stall_error", 32'(bus.error), 32'd1);
    check("stall_snk_count", 32'(snk_n - snk0), 32'd1);
    check("stall_word0", snk_mem[0], 32'h1122_3344);
    rx_en = 1'b0;
    rx_tail = rx_head;

    // Reset in the middle of a WRITE
    tx0 = tx_n;
    issue(2'd2);
    for (int i = 0; i < 200 && (tx_n - tx0) < 3; i++) @(negedge clk);
    check("midwrite_progress", 32'((tx_n - tx0) >= 3), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midwrite_tx_stb", 32'(bus.s_tx_stb), 32'd0);
    check("midwrite_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midwrite_src_en", 32'(bus.src_en), 32'd0);
    tx0 = tx_n;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midwrite_no_trailing", 32'(tx_n - tx0), 32'd0);

    // CLEAR followed by TEST
    tx0 = tx_n;
    issue(2'd1);
    wait_done("clear", int'(CLEAR_WAIT) + 100);
    check("clear_error", 32'(bus.error), 32'd0);
    check("clear_tx_count", 32'(tx_n - tx0), 32'd1);
    check("clear_cmd_byte", 32'(tx_log[tx0]), 32'h63);
    ack0 = ack_n;
    push_rx(8'h79);
    rx_en = 1'b1;
    issue(2'd0);
    wait_done("clear_test", 500);
    @(negedge clk);
    check("clear_test_byte", 32'(tx_log[tx0 + 1]), 32'h74);
    check("clear_test_error", 32'(bus.error), 32'd0);
    check("clear_test_ack", 32'(ack_n - ack0), 32'd1);
    check("clear_wait_elapsed", 32'((tx_cyc[tx0 + 1] - tx_cyc[tx0]) > int'(CLEAR_WAIT)), 32'd1);
    check("done_ready_overlap", 32'(overlap_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
